// File: rtl/mvm_result_drain_if.sv
// Result/addend memory read port and the drained word stream of mvm_result_drain.
// The master side is the drain; the slave side is the memories plus the downstream consumer.
interface mvm_result_drain_if #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned PROC_SIZE = 64
);
    logic [ADDR_W-1:0]    o_res_addr;
    logic                 o_res_en;
    logic [PROC_SIZE-1:0] i_res;
    logic [ADDR_W-1:0]    o_add_addr;
    logic [PROC_SIZE-1:0] i_add;
    logic [PROC_SIZE-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;

    modport master (
        output o_res_addr, o_res_en, o_add_addr, o_data, o_valid, o_last,
        input  i_res, i_add, i_ready
    );

    modport slave (
        input  o_res_addr, o_res_en, o_add_addr, o_data, o_valid, o_last,
        output i_res, i_add, i_ready
    );
endinterface

// File: rtl/mvm_result_drain.sv
// Drains the GF(256) MVM result memory into a valid/ready word stream, optionally adding a
// second vector and zeroing the unused tail bytes of the final word.
module mvm_result_drain #(
    parameter              PARAMETER_SET = "L3",
    parameter int unsigned N_GF          = 8,
    parameter bit          ADD_EN        = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    mvm_result_drain_if.master bus,
    output logic               o_busy,
    output logic               o_done
);
    localparam int unsigned RES_SIZE_BYTES = (PARAMETER_SET == "L1") ? 104 :
                                             (PARAMETER_SET == "L2") ? 159 :
                                             (PARAMETER_SET == "L3") ? 202 : 8;
    localparam int unsigned PROC_SIZE  = N_GF * 8;
    localparam int unsigned N_WORDS    = (RES_SIZE_BYTES + N_GF - 1) / N_GF;
    localparam int unsigned TAIL_BYTES = RES_SIZE_BYTES - (N_WORDS - 1) * N_GF;
    localparam int unsigned ADDR_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(N_WORDS - 1);
    localparam logic [PROC_SIZE-1:0] TAIL_MASK = {PROC_SIZE{1'b1}} << ((N_GF - TAIL_BYTES) * 8);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0]    next_q;
    logic [ADDR_W-1:0]    last_addr_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [PROC_SIZE-1:0] fifo_data_q [2];
    logic [1:0]           fifo_last_q;
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           count_q;

    logic                 valid;
    logic                 pop;
    logic                 issue;
    logic                 is_last_addr;
    logic                 fifo_drained;
    logic [2:0]           credit;
    logic [PROC_SIZE-1:0] ret_word;

    always_comb begin
        valid        = (count_q != 2'd0);
        pop          = valid && bus.i_ready;
        credit       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue        = (state_q == StRead) && (credit < 3'd2);
        is_last_addr = (next_q == LAST_ADDR);
        // Counts the word leaving this cycle so DONE follows the final handshake directly.
        fifo_drained = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
        ret_word     = bus.i_res ^ (ADD_EN ? bus.i_add : '0);
        if (inflight_last_q) begin
            ret_word = ret_word & TAIL_MASK;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRead;
            StRead:  if (issue && is_last_addr) state_d = StDrain;
            StDrain: if (fifo_drained) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            next_q          <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && is_last_addr;
            if ((state_q == StIdle) && i_start) begin
                next_q <= '0;
            end else if (issue && !is_last_addr) begin
                next_q <= next_q + 1'b1;
            end
            if (issue) begin
                last_addr_q <= next_q;
            end
            if (inflight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // Storage needs no reset: the head is only exposed while count_q is non-zero.
    always_ff @(posedge i_clk) begin
        if (inflight_q) begin
            fifo_data_q[wr_ptr_q] <= ret_word;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    assign bus.o_res_en   = issue;
    assign bus.o_res_addr = issue ? next_q : last_addr_q;
    assign bus.o_add_addr = issue ? next_q : last_addr_q;
    assign bus.o_valid    = valid;
    assign bus.o_data     = valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.o_last     = valid && fifo_last_q[rd_ptr_q];
    assign o_busy         = (state_q != StIdle);
    assign o_done         = (state_q == StDone);
endmodule

// File: tb/tb_mvm_result_drain.sv
// Bench for mvm_result_drain: three parameter sets with behavioural memories and a queue of
// expected words that is filled before each run and emptied as words are handshaken.
module tb_mvm_result_drain;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_l1, start_l2, start_l3;
    logic busy_l1, busy_l2, busy_l3;
    logic done_l1, done_l2, done_l3;

    int tests = 0;
    int fails = 0;
    logic [64:0] sb [$];

    mvm_result_drain_if #(.ADDR_W(4), .PROC_SIZE(64)) if_l1 ();
    mvm_result_drain_if #(.ADDR_W(5), .PROC_SIZE(64)) if_l2 ();
    mvm_result_drain_if #(.ADDR_W(5), .PROC_SIZE(64)) if_l3 ();

    mvm_result_drain #(.PARAMETER_SET("L1"), .N_GF(8), .ADD_EN(1'b0)) u_l1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_l1), .bus(if_l1),
        .o_busy(busy_l1), .o_done(done_l1)
    );
    mvm_result_drain #(.PARAMETER_SET("L2"), .N_GF(8), .ADD_EN(1'b1)) u_l2 (
        .i_clk(clk), .i_rst(rst), .i_start(start_l2), .bus(if_l2),
        .o_busy(busy_l2), .o_done(done_l2)
    );
    mvm_result_drain #(.PARAMETER_SET("L3"), .N_GF(8), .ADD_EN(1'b1)) u_l3 (
        .i_clk(clk), .i_rst(rst), .i_start(start_l3), .bus(if_l3),
        .o_busy(busy_l3), .o_done(done_l3)
    );

    function automatic logic [63:0] l1_res_fn(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k);
    endfunction
    function automatic logic [63:0] l1_add_fn(input int k);
        return 64'hA5C3_5A3C_9696_6969 ^ 64'(k);
    endfunction
    function automatic logic [63:0] l2_res_fn(input int k);
        return {8{8'(k)}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction
    function automatic logic [63:0] l2_add_fn(input int k);
        return {8{8'(3 * k + 1)}};
    endfunction

    // Memories: one-cycle read latency, junk on cycles with no read.
    logic [63:0] l1_res_q, l1_add_q, l2_res_q, l2_add_q, l3_res_q, l3_add_q;
    always @(posedge clk) begin
        l1_res_q <= if_l1.o_res_en ? l1_res_fn(int'(if_l1.o_res_addr)) : 64'hDEAD_BEEF_0BAD_F00D;
        l1_add_q <= if_l1.o_res_en ? l1_add_fn(int'(if_l1.o_add_addr)) : 64'hFFFF_0000_FFFF_0000;
        l2_res_q <= if_l2.o_res_en ? l2_res_fn(int'(if_l2.o_res_addr)) : 64'hDEAD_BEEF_0BAD_F00D;
        l2_add_q <= if_l2.o_res_en ? l2_add_fn(int'(if_l2.o_add_addr)) : 64'h1357_9BDF_2468_ACE0;
        l3_res_q <= if_l3.o_res_en ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1234_5678_9ABC_DEF0;
        l3_add_q <= if_l3.o_res_en ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h0000_0000_0000_0000;
    end
    assign if_l1.i_res = l1_res_q;
    assign if_l1.i_add = l1_add_q;
    assign if_l2.i_res = l2_res_q;
    assign if_l2.i_add = l2_add_q;
    assign if_l3.i_res = l3_res_q;
    assign if_l3.i_add = l3_add_q;

    // Leaves the caller #1 after the edge that sampled i_start, i.e. inside cycle 1.
    task automatic kick(input int which);
        @(posedge clk);
        #1;
        if (which == 1) start_l1 = 1'b1;
        else if (which == 2) start_l2 = 1'b1;
        else start_l3 = 1'b1;
        @(posedge clk);
        #1;
        start_l1 = 1'b0;
        start_l2 = 1'b0;
        start_l3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy_l1, done_l1, if_l1.o_res_en, if_l1.o_valid, if_l1.o_last, if_l1.o_res_addr,
             if_l1.o_add_addr, if_l1.o_data} !== '0) begin
            fails++;
            $display("FAIL reset_l1: busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h, want all 0",
                     busy_l1, done_l1, if_l1.o_res_en, if_l1.o_valid, if_l1.o_last,
                     if_l1.o_res_addr, if_l1.o_data);
        end
        tests++;
        if ({busy_l2, done_l2, if_l2.o_res_en, if_l2.o_valid, if_l2.o_last, if_l2.o_res_addr,
             if_l2.o_add_addr, if_l2.o_data} !== '0) begin
            fails++;
            $display("FAIL reset_l2: busy=%b done=%b en=%b valid=%b addr=%h data=%h, want all 0",
                     busy_l2, done_l2, if_l2.o_res_en, if_l2.o_valid, if_l2.o_res_addr, if_l2.o_data);
        end
        tests++;
        if ({busy_l3, done_l3, if_l3.o_res_en, if_l3.o_valid, if_l3.o_last, if_l3.o_res_addr,
             if_l3.o_add_addr, if_l3.o_data} !== '0) begin
            fails++;
            $display("FAIL reset_l3: busy=%b done=%b en=%b valid=%b addr=%h data=%h, want all 0",
                     busy_l3, done_l3, if_l3.o_res_en, if_l3.o_valid, if_l3.o_res_addr, if_l3.o_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_l1_stream();
        int k = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        logic [64:0] exp;
        sb.delete();
        for (int i = 0; i < 13; i++) sb.push_back({i == 12, l1_res_fn(i)});
        if_l1.i_ready = 1'b1;
        kick(1);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                tests++;
                if (if_l1.o_res_en !== 1'b1 || if_l1.o_res_addr !== 4'd0 || busy_l1 !== 1'b1) begin
                    fails++;
                    $display("FAIL l1_first_read: en=%b addr=%0d busy=%b, want en=1 addr=0 busy=1",
                             if_l1.o_res_en, if_l1.o_res_addr, busy_l1);
                end
            end
            if (if_l1.o_valid === 1'b1) begin
                tests++;
                exp = '0;
                if (sb.size() > 0) exp = sb.pop_front();
                if (if_l1.o_data !== exp[63:0] || if_l1.o_last !== exp[64] || cyc != 3 + k) begin
                    fails++;
                    $display("FAIL l1_word%0d: got data=%h last=%b cyc=%0d, want data=%h last=%b cyc=%0d",
                             k, if_l1.o_data, if_l1.o_last, cyc, exp[63:0], exp[64], 3 + k);
                end
                k++;
            end
            if (done_l1 === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (k != 13) begin
            fails++;
            $display("FAIL l1_word_count: got %0d, want 13", k);
        end
        tests++;
        if (done_cnt != 1 || done_cyc != 16) begin
            fails++;
            $display("FAIL l1_done: got %0d pulses last at cycle %0d, want 1 pulse at cycle 16",
                     done_cnt, done_cyc);
        end
        tests++;
        if (busy_l1 !== 1'b0 || if_l1.o_valid !== 1'b0) begin
            fails++;
            $display("FAIL l1_idle_after: busy=%b valid=%b, want 0 0", busy_l1, if_l1.o_valid);
        end
    endtask

    task automatic test_l3_addend();
        int k = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        logic [64:0] exp;
        sb.delete();
        for (int i = 0; i < 26; i++) begin
            sb.push_back({i == 25, (i == 25) ? 64'hF0F0_0000_0000_0000 : 64'hF0F0_F0F0_F0F0_F0F0});
        end
        if_l3.i_ready = 1'b1;
        kick(3);
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            if (if_l3.o_valid === 1'b1) begin
                tests++;
                exp = '0;
                if (sb.size() > 0) exp = sb.pop_front();
                if (if_l3.o_data !== exp[63:0] || if_l3.o_last !== exp[64] || cyc != 3 + k) begin
                    fails++;
                    $display("FAIL l3_word%0d: got data=%h last=%b cyc=%0d, want data=%h last=%b cyc=%0d",
                             k, if_l3.o_data, if_l3.o_last, cyc, exp[63:0], exp[64], 3 + k);
                end
                k++;
            end
            if (done_l3 === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (k != 26 || done_cnt != 1 || done_cyc != 29) begin
            fails++;
            $display("FAIL l3_summary: words=%0d done=%0d at %0d, want 26 words, 1 done at 29",
                     k, done_cnt, done_cyc);
        end
    endtask

    task automatic test_l2_backpressure();
        logic [3:0] pat = 4'b1001;
        int issued = 0;
        int accepted = 0;
        int max_out = 0;
        int done_cnt = 0;
        logic prev_stall = 1'b0;
        logic [63:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [63:0] e;
        logic [64:0] exp;
        sb.delete();
        for (int i = 0; i < 20; i++) begin
            e = l2_res_fn(i) ^ l2_add_fn(i);
            if (i == 19) e[7:0] = 8'h00;
            sb.push_back({i == 19, e});
        end
        if_l2.i_ready = 1'b1;
        kick(2);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if_l2.i_ready = pat[(cyc - 1) % 4];
            @(negedge clk);
            if (prev_stall) begin
                tests++;
                if (if_l2.o_valid !== 1'b1 || if_l2.o_data !== prev_data || if_l2.o_last !== prev_last) begin
                    fails++;
                    $display("FAIL l2_hold cyc%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                             cyc, if_l2.o_valid, if_l2.o_data, if_l2.o_last, prev_data, prev_last);
                end
            end
            if (if_l2.o_res_en === 1'b1) begin
                tests++;
                if (if_l2.o_res_addr !== 5'(issued) || if_l2.o_add_addr !== 5'(issued)) begin
                    fails++;
                    $display("FAIL l2_addr: got res=%0d add=%0d, want %0d",
                             if_l2.o_res_addr, if_l2.o_add_addr, issued);
                end
                issued++;
            end
            if (if_l2.o_valid === 1'b1 && if_l2.i_ready === 1'b1) begin
                tests++;
                exp = '0;
                if (sb.size() > 0) exp = sb.pop_front();
                if (if_l2.o_data !== exp[63:0] || if_l2.o_last !== exp[64]) begin
                    fails++;
                    $display("FAIL l2_word%0d: got data=%h last=%b, want data=%h last=%b",
                             accepted, if_l2.o_data, if_l2.o_last, exp[63:0], exp[64]);
                end
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = (if_l2.o_valid === 1'b1) && (if_l2.i_ready === 1'b0);
            prev_data = if_l2.o_data;
            prev_last = if_l2.o_last;
            if (done_l2 === 1'b1) done_cnt++;
            @(posedge clk);
            #1;
        end
        if_l2.i_ready = 1'b1;
        tests++;
        if (accepted != 20 || issued != 20 || sb.size() != 0) begin
            fails++;
            $display("FAIL l2_counts: accepted=%0d issued=%0d left=%0d, want 20 20 0",
                     accepted, issued, sb.size());
        end
        tests++;
        if (max_out > 2) begin
            fails++;
            $display("FAIL l2_outstanding: got max %0d, want at most 2", max_out);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL l2_done: got %0d pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_l1_stall();
        int reads = 0;
        int k = 0;
        int done_cnt = 0;
        logic [3:0] a0 = 4'hF;
        logic [3:0] a1 = 4'hF;
        logic en_at_10 = 1'b1;
        logic [64:0] exp;
        sb.delete();
        for (int i = 0; i < 13; i++) sb.push_back({i == 12, l1_res_fn(i)});
        if_l1.i_ready = 1'b0;
        kick(1);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            if (cyc == 11) if_l1.i_ready = 1'b1;
            @(negedge clk);
            if (cyc <= 10 && if_l1.o_res_en === 1'b1) begin
                if (reads == 0) a0 = if_l1.o_res_addr;
                else if (reads == 1) a1 = if_l1.o_res_addr;
                reads++;
            end
            if (cyc == 10) en_at_10 = if_l1.o_res_en;
            if (cyc >= 3 && cyc <= 10) begin
                tests++;
                if (if_l1.o_valid !== 1'b1 || if_l1.o_data !== l1_res_fn(0) || if_l1.o_last !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b data=%h, want 1 %h",
                             cyc, if_l1.o_valid, if_l1.o_data, l1_res_fn(0));
                end
            end
            if (cyc == 11) begin
                tests++;
                if (if_l1.o_res_en !== 1'b1 || if_l1.o_res_addr !== 4'd2) begin
                    fails++;
                    $display("FAIL stall_resume: got en=%b addr=%0d, want en=1 addr=2",
                             if_l1.o_res_en, if_l1.o_res_addr);
                end
            end
            if (if_l1.o_valid === 1'b1 && if_l1.i_ready === 1'b1) begin
                tests++;
                exp = '0;
                if (sb.size() > 0) exp = sb.pop_front();
                if (if_l1.o_data !== exp[63:0] || if_l1.o_last !== exp[64]) begin
                    fails++;
                    $display("FAIL stall_word%0d: got data=%h last=%b, want data=%h last=%b",
                             k, if_l1.o_data, if_l1.o_last, exp[63:0], exp[64]);
                end
                k++;
            end
            if (done_l1 === 1'b1) done_cnt++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (reads != 2 || a0 !== 4'd0 || a1 !== 4'd1 || en_at_10 !== 1'b0) begin
            fails++;
            $display("FAIL stall_reads: got %0d reads addr %0d,%0d en@10=%b, want 2 reads 0,1 en@10=0",
                     reads, a0, a1, en_at_10);
        end
        tests++;
        if (k != 13 || done_cnt != 1) begin
            fails++;
            $display("FAIL stall_summary: words=%0d done=%0d, want 13 and 1", k, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        if_l1.i_ready = 1'b1;
        kick(1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy_l1, done_l1, if_l1.o_res_en, if_l1.o_valid, if_l1.o_last, if_l1.o_res_addr,
             if_l1.o_add_addr, if_l1.o_data} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: busy=%b done=%b en=%b valid=%b addr=%h data=%h, want all 0",
                     busy_l1, done_l1, if_l1.o_res_en, if_l1.o_valid, if_l1.o_res_addr, if_l1.o_data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_l1 !== 1'b0 || busy_l1 !== 1'b0 || if_l1.o_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_quiet: got %0d active cycles after reset, want 0", bad);
        end
        test_l1_stream();
    endtask

    task automatic test_second_start();
        int issued = 0;
        int k = 0;
        int done_cnt = 0;
        logic [64:0] exp;
        sb.delete();
        for (int i = 0; i < 13; i++) sb.push_back({i == 12, l1_res_fn(i)});
        if_l1.i_ready = 1'b1;
        kick(1);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            start_l1 = (cyc == 4);
            @(negedge clk);
            if (if_l1.o_res_en === 1'b1) begin
                tests++;
                if (if_l1.o_res_addr !== 4'(issued)) begin
                    fails++;
                    $display("FAIL restart_addr: got %0d, want %0d", if_l1.o_res_addr, issued);
                end
                issued++;
            end
            if (if_l1.o_valid === 1'b1) begin
                tests++;
                exp = '0;
                if (sb.size() > 0) exp = sb.pop_front();
                if (if_l1.o_data !== exp[63:0] || if_l1.o_last !== exp[64]) begin
                    fails++;
                    $display("FAIL restart_word%0d: got data=%h last=%b, want data=%h last=%b",
                             k, if_l1.o_data, if_l1.o_last, exp[63:0], exp[64]);
                end
                k++;
            end
            if (done_l1 === 1'b1) done_cnt++;
            @(posedge clk);
            #1;
        end
        start_l1 = 1'b0;
        tests++;
        if (issued != 13 || k != 13 || done_cnt != 1) begin
            fails++;
            $display("FAIL restart_summary: reads=%0d words=%0d done=%0d, want 13 13 1",
                     issued, k, done_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_l1 = 1'b0;
        start_l2 = 1'b0;
        start_l3 = 1'b0;
        if_l1.i_ready = 1'b0;
        if_l2.i_ready = 1'b0;
        if_l3.i_ready = 1'b0;
        test_reset();
        test_l1_stream();
        test_l3_addend();
        test_l2_backpressure();
        test_l1_stall();
        test_reset_mid();
        test_second_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
